ahb_mem_slave: RTL and testbench

- Single-port 64-bit data memory acting as the bus responder for the memory-access stage's HADDR/HTRANS/HWRITE/HWDATA/HRDATA interface.
- Accepts one transfer per address phase and inserts a programmable number of wait states through HREADY.
- Returns the addressed word on reads, and also during the write data phase, so the master can perform sub-word read-modify-write merges.
- Sits between the pipeline's memory stage and the on-chip data RAM; flags out-of-range accesses through HRESP.

---
 rtl/ahb_mem_slave.sv | 110 +++++++++++
 tb/tb_ahb_mem_slave.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave.sv
// AHB-style 64-bit data memory responder; data phase lasts WAIT_STATES+1 cycles, HRDATA valid on the HREADY-high cycle.
// Backpressure: HREADY low during wait states; out-of-range transfers get a single-cycle HRESP with no write.
module ahb_mem_slave #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [63:0] BASE_ADDR   = 64'h0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [63:0] HADDR,
   input  logic        HTRANS,
   input  logic        HWRITE,
   input  logic [63:0] HWDATA,
   output logic [63:0] HRDATA,
   output logic        HREADY,
   output logic        HRESP
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, WAIT, LAST} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic              wr;
      logic              err;
   } xfer_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   xfer_t             cur, new_xfer;
   logic [63:0]       mem [DEPTH];
   logic [60:0]       word_off;
   logic              capture, commit, load_rd, rd_err, fwd;
   logic [ADDR_W-1:0] rd_idx;

   assign HREADY  = (state != WAIT);
   assign HRESP   = (state == LAST) && cur.err;
   assign capture = HTRANS && HREADY;
   assign commit  = (state == LAST) && cur.wr && !cur.err;

   // BASE_ADDR is word aligned, so the offset is taken on word addresses directly.
   assign word_off = HADDR[63:3] - BASE_ADDR[63:3];

   always_comb begin
      new_xfer.idx = word_off[ADDR_W-1:0];
      new_xfer.wr  = HWRITE;
      new_xfer.err = (HADDR < BASE_ADDR) || (|word_off[60:ADDR_W]);
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE, LAST: begin
            if (capture) begin
               if (WAIT_STATES == 0) begin
                  state_nxt = LAST;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = 4'(WAIT_STATES - 1);
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_nxt = LAST;
            else             cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // With no wait states the word is fetched at capture time and may collide with a committing write.
   always_comb begin
      if (WAIT_STATES == 0) begin
         load_rd = capture;
         rd_idx  = new_xfer.idx;
         rd_err  = new_xfer.err;
      end else begin
         load_rd = (state == WAIT) && (cnt == 4'd0);
         rd_idx  = cur.idx;
         rd_err  = cur.err;
      end
      fwd = commit && (rd_idx == cur.idx);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         cur    <= '0;
         HRDATA <= 64'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (capture) cur <= new_xfer;
         if (load_rd) begin
            if (rd_err)   HRDATA <= 64'd0;
            else if (fwd) HRDATA <= HWDATA;
            else          HRDATA <= mem[rd_idx];
         end
      end
   end

   // Memory is never cleared; a reset only suppresses the pending commit.
   always_ff @(posedge CLK) begin
      if (!RESET && commit) mem[cur.idx] <= HWDATA;
   end
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: three instances (0, 1 and 3 wait states, 16-word memory) checked
// every cycle against a transfer-timing model, plus directed literal checks.
module tb_ahb_mem_slave;
   logic        clk;
   logic        armed;
   logic        rst    [3];
   logic [63:0] haddr  [3];
   logic [63:0] hwdata [3];
   logic [63:0] hrdata [3];
   logic        htrans [3];
   logic        hwrite [3];
   logic        hready [3];
   logic        hresp  [3];
   logic [63:0] wq     [3];
   int          n_chk = 0;
   int          n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_u
      localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

      ahb_mem_slave #(.ADDR_W(4), .WAIT_STATES(WS), .BASE_ADDR(64'h0)) u_dut (
         .CLK    (clk),
         .RESET  (rst[g]),
         .HADDR  (haddr[g]),
         .HTRANS (htrans[g]),
         .HWRITE (hwrite[g]),
         .HWDATA (hwdata[g]),
         .HRDATA (hrdata[g]),
         .HREADY (hready[g]),
         .HRESP  (hresp[g])
      );

      // Model: a transfer accepted at edge a is waiting until edge a+WS, responds after
      // edge a+WS, and its write lands at edge a+WS+1.
      logic [63:0] mem_m [16];
      bit          known [16];
      int          cyc = 0, a = 0, idx = 0;
      bit          vld = 0, wr = 0, err = 0, rk = 0, e_ready = 1, e_resp = 0;
      logic [63:0] e_rdata = '0;

      initial forever begin
         @(posedge clk);
         cyc++;
         if (rst[g]) begin
            vld = 0; e_ready = 1; e_resp = 0; e_rdata = '0; rk = 1;
         end else begin
            if (vld && cyc == a + WS + 1) begin
               if (wr && !err) begin
                  mem_m[idx] = hwdata[g];
                  known[idx] = 1;
               end
               vld = 0;
            end
            if (htrans[g] && e_ready) begin
               vld = 1; a = cyc; wr = hwrite[g];
               err = (haddr[g] >= 64'd128);
               idx = int'(haddr[g][6:3]);
            end
            e_ready = !(vld && cyc < a + WS);
            e_resp  = vld && (cyc == a + WS) && err;
            if (vld && cyc == a + WS) begin
               e_rdata = err ? 64'd0 : mem_m[idx];
               rk      = err || known[idx];
            end
         end
      end

      initial forever begin
         @(posedge clk);
         #1;
         if (armed) begin
            check($sformatf("u%0d hready", g), 64'(hready[g]), 64'(e_ready));
            check($sformatf("u%0d hresp", g), 64'(hresp[g]), 64'(e_resp));
            if (rk) check($sformatf("u%0d hrdata", g), hrdata[g], e_rdata);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the address phase was accepted.
   task automatic addr_phase(input int k, input bit wr, input logic [63:0] adr, input logic [63:0] dat);
      int n = 0;
      htrans[k] = 1'b1; hwrite[k] = wr; haddr[k] = adr; hwdata[k] = wq[k];
      while (!hready[k] && n < 40) begin
         @(negedge clk);
         hwdata[k] = wq[k];
         n++;
      end
      check($sformatf("u%0d accept", k), 64'(hready[k]), 64'd1);
      wq[k] = dat;
      @(negedge clk);
      htrans[k] = 1'b0;
      hwdata[k] = dat;
   endtask

   task automatic wait_rdy(input int k);
      for (int n = 0; n < 40 && !hready[k]; n++) @(negedge clk);
      check($sformatf("u%0d ready timeout", k), 64'(hready[k]), 64'd1);
   endtask

   initial begin
      armed = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; htrans[k] = 1'b0; hwrite[k] = 1'b0;
         haddr[k] = '0; hwdata[k] = '0; wq[k] = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      armed = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check("reset hready", 64'(hready[k]), 64'd1);
         check("reset hresp", 64'(hresp[k]), 64'd0);
         check("reset hrdata", hrdata[k], 64'd0);
      end

      // One wait state: write then read back.
      addr_phase(1, 1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567);
      check("t1 wr wait", 64'(hready[1]), 64'd0);
      addr_phase(1, 1'b0, 64'h10, 64'd0);
      check("t1 rd wait", 64'(hready[1]), 64'd0);
      @(negedge clk);
      check("t1 rd data", hrdata[1], 64'hDEAD_BEEF_0123_4567);
      check("t1 rd ready", 64'(hready[1]), 64'd1);
      check("t1 rd resp", 64'(hresp[1]), 64'd0);

      // Write-then-write: second write's last cycle shows the old word.
      addr_phase(1, 1'b1, 64'h30, 64'hFFFF_FFFF_FFFF_FFFF);
      addr_phase(1, 1'b1, 64'h30, 64'h1234);
      @(negedge clk);
      check("t3 rmw old word", hrdata[1], 64'hFFFF_FFFF_FFFF_FFFF);
      check("t3 rmw ready", 64'(hready[1]), 64'd1);
      addr_phase(1, 1'b0, 64'h30, 64'd0);
      wait_rdy(1);
      check("t3 readback", hrdata[1], 64'h1234);

      // Idle bus with toggling address/control.
      for (int i = 0; i < 5; i++) begin
         haddr[1]  = {$urandom, $urandom};
         hwrite[1] = ~hwrite[1];
         hwdata[1] = {$urandom, $urandom};
         @(negedge clk);
         check("t6 idle ready", 64'(hready[1]), 64'd1);
         check("t6 idle hold", hrdata[1], 64'h1234);
      end
      addr_phase(1, 1'b0, 64'h10, 64'd0);
      wait_rdy(1);
      check("t6 no stray write", hrdata[1], 64'hDEAD_BEEF_0123_4567);

      // Zero wait states: back-to-back write/read to the same word forwards write data.
      addr_phase(0, 1'b1, 64'h20, 64'h55);
      check("t2 wr ready", 64'(hready[0]), 64'd1);
      addr_phase(0, 1'b0, 64'h20, 64'd0);
      check("t2 fwd data", hrdata[0], 64'h55);
      check("t2 rd ready", 64'(hready[0]), 64'd1);

      // Out-of-range read and write; word 0 must survive.
      addr_phase(0, 1'b1, 64'h0, 64'hA5A5);
      addr_phase(0, 1'b0, 64'h80, 64'd0);
      check("t4 rd err resp", 64'(hresp[0]), 64'd1);
      check("t4 rd err data", hrdata[0], 64'd0);
      addr_phase(0, 1'b1, 64'h80, 64'h777);
      check("t4 wr err resp", 64'(hresp[0]), 64'd1);
      @(negedge clk);
      check("t4 err one cycle", 64'(hresp[0]), 64'd0);
      addr_phase(0, 1'b0, 64'h0, 64'd0);
      check("t4 word0 kept", hrdata[0], 64'hA5A5);

      // Three wait states: reset mid-write aborts it.
      addr_phase(2, 1'b1, 64'h40, 64'h4040_4040);
      wait_rdy(2);
      @(negedge clk);
      addr_phase(2, 1'b1, 64'h40, 64'hBAD);
      check("t5 in wait", 64'(hready[2]), 64'd0);
      rst[2] = 1'b1;
      @(negedge clk);
      rst[2] = 1'b0;
      check("t5 rst ready", 64'(hready[2]), 64'd1);
      check("t5 rst resp", 64'(hresp[2]), 64'd0);
      check("t5 rst data", hrdata[2], 64'd0);
      addr_phase(2, 1'b0, 64'h40, 64'd0);
      wait_rdy(2);
      check("t5 prior contents", hrdata[2], 64'h4040_4040);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
